multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing FSM for the multi-cycle RV32I datapath: one shared memory port, one ALU, and IR/PC/OldPC/ALUOut holding registers. Each instruction is stepped through fetch, decode, execute, memory and writeback. The block drives every datapath enable and mux select and stalls on a memory ready handshake. It covers the same opcode classes as the single-cycle decoder: R-type, load, store, I-type ALU and branch.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- instruction_i  in  32  IR contents; stable from the cycle after IRWrite
- mem_ready_i  in  1  memory completes the current read/write this cycle
- branch_taken_i  in  1  ALU comparison result for the current branch (funct3 already applied)
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR and OldPC load enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write enable
- PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = immediate
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct
- illegal_o  out  1  high while halted on an unsupported opcode
- state_o  out  3  current state encoding, for debug

## Operation
States: FETCH, DECODE, EXECUTE, BRANCH, MEM_READ, MEM_WRITE, WRITEBACK, TRAP.

Unlisted outputs are 0 in each state.

- FETCH
  - Outputs: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - If mem_ready_i is high: IRWrite=1 and PCWrite=1 (PC <= PC+4), next state DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00. This computes OldPC+imm into ALUOut.
  - Next state by opcode: 0110011, 0010011, 0000011, 0100011 go to EXECUTE; 1100011 goes to BRANCH; any other opcode goes to TRAP.
- EXECUTE
  - Outputs: ALUSrcA=10.
  - R-type: ALUSrcB=00, ALUOp=10, next state WRITEBACK.
  - I-type: ALUSrcB=10, ALUOp=11, next state WRITEBACK.
  - Load: ALUSrcB=10, ALUOp=00, next state MEM_READ.
  - Store: ALUSrcB=10, ALUOp=00, next state MEM_WRITE.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=branch_taken_i.
  - Next state FETCH.
- MEM_READ
  - Outputs: IorD=1, MemRead=1.
  - Stay until mem_ready_i is high, then go to WRITEBACK.
- MEM_WRITE
  - Outputs: IorD=1, MemWrite=1.
  - Stay until mem_ready_i is high, then go to FETCH.
- WRITEBACK
  - Outputs: RegWrite=1; MemtoReg=1 only when the opcode is load.
  - Next state FETCH.
- TRAP
  - All strobes are 0 and illegal_o=1.
  - The block stays in TRAP until rst_i.

Output dependencies:
- PCWrite and IRWrite are Mealy outputs (they depend on mem_ready_i or branch_taken_i).
- All other outputs are functions of state and opcode only.

## Timing
- Reset:
  - rst_i is sampled on the clk_i edge; the next state is FETCH.
  - While rst_i is high, every strobe (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) and illegal_o is forced to 0.
  - Reset asserted mid-operation (including during a memory wait) abandons the instruction. No write strobe fires in the reset cycle.
- Latency with zero-wait memory (mem_ready_i high in the first request cycle):
  - Branch: 3 cycles.
  - R-type, I-type and store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Handshake:
  - MemRead/MemWrite and IorD are held constant from the first request cycle through the ready cycle.
  - A request is never dropped before ready.
  - mem_ready_i is ignored outside FETCH, MEM_READ and MEM_WRITE.
- At most one of MemRead/MemWrite is high in any cycle. RegWrite and MemWrite are never both high.
- state_o encoding: FETCH=0, DECODE=1, EXECUTE=2, BRANCH=3, MEM_READ=4, MEM_WRITE=5, WRITEBACK=6, TRAP=7.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_RTYPE, OP_LOAD, OP_STORE, OP_ITYPE, OP_BRANCH);
  - the state enum;
  - the ALUSrcA, ALUSrcB and ALUOp encodings, so the datapath muxes and the ALU control use the same values.
- Single module with no sub-module: one registered state, one combinational next-state block and one combinational output block.

## Test plan
- **add (0x002081B3), mem_ready_i held high:** states 0,1,2,6,0. IRWrite and PCWrite pulse in cycle 0. In cycle 2, ALUOp=10 and ALUSrcB=00. In cycle 3, RegWrite=1 and MemtoReg=0.
- **lw (0x0000A103), ready delayed 3 cycles in both FETCH and MEM_READ:** 11 cycles total. MemRead and IorD stay stable across the waits. WRITEBACK has MemtoReg=1.
- **beq (0x00208463):**
  - branch_taken_i=1: PCWrite=1 with PCSource=1 in BRANCH.
  - branch_taken_i=0: PCWrite=0.
  - Both cases take 3 cycles.
- **sw (0x0020A023), ready after 2 wait cycles:** MemWrite=1 for 3 cycles and RegWrite never asserts. The next state after the ready cycle is FETCH.
- **Opcode 0x7F:** TRAP entered after DECODE. illegal_o=1 is held with all strobes 0 for 10 or more cycles. rst_i then returns the block to FETCH with illegal_o=0.
- **rst_i pulsed during a MEM_READ wait:** no RegWrite in any later cycle for that load. The next state is FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, FSM states and datapath mux/ALU encodings
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_BRANCH    = 3'd3,
    ST_MEM_READ  = 3'd4,
    ST_MEM_WRITE = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_TRAP      = 3'd7
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // Opcodes that proceed from DECODE through the common EXECUTE state.
  function automatic logic uses_execute(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
           (opcode == OP_LOAD)  || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - sequencing FSM for the multi-cycle RV32I datapath
module multicycle_control
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instruction_i,
  input  logic        mem_ready_i,
  input  logic        branch_taken_i,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  state_e     state_q;
  state_e     state_d;
  logic [6:0] opcode;
  logic       unused_instr_bits;

  assign opcode            = instruction_i[6:0];
  assign unused_instr_bits = ^instruction_i[31:7];
  assign state_o           = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready_i) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (uses_execute(opcode))      state_d = ST_EXECUTE;
        else if (opcode == OP_BRANCH)  state_d = ST_BRANCH;
        else                           state_d = ST_TRAP;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_RTYPE, OP_ITYPE: state_d = ST_WRITEBACK;
          OP_LOAD:            state_d = ST_MEM_READ;
          OP_STORE:           state_d = ST_MEM_WRITE;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_BRANCH:    state_d = ST_FETCH;
      ST_MEM_READ: begin
        if (mem_ready_i) state_d = ST_WRITEBACK;
      end
      ST_MEM_WRITE: begin
        if (mem_ready_i) state_d = ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_TRAP;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    PCSource  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    illegal_o = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready_i) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      ST_DECODE: begin
        // Speculative branch target OldPC+imm lands in ALUOut here.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      ST_EXECUTE: begin
        ALUSrcA = SRCA_RS1;
        case (opcode)
          OP_RTYPE: begin
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_RTYPE;
          end
          OP_ITYPE: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ITYPE;
          end
          default: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
          end
        endcase
      end
      ST_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_BRANCH;
        PCSource = 1'b1;
        PCWrite  = branch_taken_i;
      end
      ST_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ST_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode == OP_LOAD);
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
    // Reset abandons the instruction: no strobe may reach the datapath this cycle.
    if (rst_i) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      illegal_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized trace-model bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, iord, mrd, mwr, m2r, rw, pcs;
    logic [1:0] sa, sb, op;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        ready;
    logic        taken;
    logic        rst;
  } stim_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instruction_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, PCSource;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
  logic        illegal_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  stim_t stim_q[$];
  ctl_t  exp_q[$];
  ctl_t  obs_q[$];

  multicycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .instruction_i(instruction_i),
    .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: each instruction expands into a list of per-cycle expectations
  function automatic ctl_t base(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic stim_t rnd_stim(input logic [31:0] instr);
    stim_t s;
    s.instr = instr;
    s.ready = 1'($urandom);
    s.taken = 1'($urandom);
    s.rst   = 1'b0;
    return s;
  endfunction

  task automatic push(input stim_t s, input ctl_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_fetch(input int waits, input logic with_ready);
    stim_t s;
    ctl_t  e;
    for (int i = 0; i < waits + (with_ready ? 1 : 0); i++) begin
      s = rnd_stim($urandom);
      e = base(3'd0);
      e.mrd = 1'b1;
      e.sb  = 2'b01;
      s.ready = (i == waits);
      if (s.ready) begin
        e.irw = 1'b1;
        e.pcw = 1'b1;
      end
      push(s, e);
    end
  endtask

  task automatic add_instr(input logic [31:0] instr, input int fwait, input int mwait,
                           input logic taken);
    stim_t s;
    ctl_t  e;
    logic [6:0] opc;
    opc = instr[6:0];
    add_fetch(fwait, 1'b1);
    s = rnd_stim(instr);
    e = base(3'd1); e.sa = 2'b01; e.sb = 2'b10;
    push(s, e);
    if (opc == 7'h63) begin
      s = rnd_stim(instr); s.taken = taken;
      e = base(3'd3); e.sa = 2'b10; e.sb = 2'b00; e.op = 2'b01; e.pcs = 1'b1; e.pcw = taken;
      push(s, e);
    end else if (opc == 7'h33 || opc == 7'h13) begin
      s = rnd_stim(instr);
      e = base(3'd2); e.sa = 2'b10;
      if (opc == 7'h33) begin e.sb = 2'b00; e.op = 2'b10; end
      else              begin e.sb = 2'b10; e.op = 2'b11; end
      push(s, e);
      s = rnd_stim(instr); e = base(3'd6); e.rw = 1'b1;
      push(s, e);
    end else if (opc == 7'h03 || opc == 7'h23) begin
      s = rnd_stim(instr);
      e = base(3'd2); e.sa = 2'b10; e.sb = 2'b10;
      push(s, e);
      for (int i = 0; i <= mwait; i++) begin
        s = rnd_stim(instr);
        s.ready = (i == mwait);
        e = base(opc == 7'h03 ? 3'd4 : 3'd5);
        e.iord = 1'b1;
        if (opc == 7'h03) e.mrd = 1'b1; else e.mwr = 1'b1;
        push(s, e);
      end
      if (opc == 7'h03) begin
        s = rnd_stim(instr); e = base(3'd6); e.rw = 1'b1; e.m2r = 1'b1;
        push(s, e);
      end
    end
  endtask

  task automatic play();
    ctl_t o;
    obs_q.delete();
    foreach (stim_q[i]) begin
      @(negedge clk_i);
      instruction_i  = stim_q[i].instr;
      mem_ready_i    = stim_q[i].ready;
      branch_taken_i = stim_q[i].taken;
      rst_i          = stim_q[i].rst;
      #1;
      o.st = state_o; o.pcw = PCWrite; o.irw = IRWrite; o.iord = IorD; o.mrd = MemRead;
      o.mwr = MemWrite; o.m2r = MemtoReg; o.rw = RegWrite; o.pcs = PCSource;
      o.sa = ALUSrcA; o.sb = ALUSrcB; o.op = ALUOp; o.ill = illegal_o;
      obs_q.push_back(o);
    end
  endtask

  task automatic clear();
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    mem_ready_i = 1'b1;
    branch_taken_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    checks++;
    if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if ({state_o, MemRead, IRWrite, PCWrite} !== {3'd0, 3'b100}) begin
      errors++;
      $display("FAIL reset_release: got st=%0d rd=%b ir=%b pc=%b expected st=0 rd=1 ir=0 pc=0",
               state_o, MemRead, IRWrite, PCWrite);
    end
  endtask

  task automatic test_add();
    clear();
    add_instr(32'h002081B3, 0, 0, 1'b0);
    add_fetch(1, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL add cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lw();
    clear();
    add_instr(32'h0000A103, 3, 3, 1'b0);
    add_fetch(1, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_beq();
    clear();
    add_instr(32'h00208463, 0, 0, 1'b1);
    add_instr(32'h00208463, 0, 0, 1'b0);
    add_fetch(1, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL beq cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sw();
    clear();
    add_instr(32'h0020A023, 0, 2, 1'b0);
    add_fetch(1, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sw cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_trap();
    stim_t s;
    ctl_t  e;
    clear();
    add_fetch(1, 1'b1);
    s = rnd_stim(32'h0000007F);
    e = base(3'd1); e.sa = 2'b01; e.sb = 2'b10;
    push(s, e);
    for (int i = 0; i < 12; i++) begin
      s = rnd_stim(32'h0000007F);
      e = base(3'd7); e.ill = 1'b1;
      push(s, e);
    end
    s = rnd_stim(32'h0000007F); s.rst = 1'b1;
    push(s, base(3'd7));
    add_fetch(2, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL trap cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    stim_t s;
    ctl_t  e;
    clear();
    add_fetch(0, 1'b1);
    s = rnd_stim(32'h0000A103);
    e = base(3'd1); e.sa = 2'b01; e.sb = 2'b10;
    push(s, e);
    s = rnd_stim(32'h0000A103);
    e = base(3'd2); e.sa = 2'b10; e.sb = 2'b10;
    push(s, e);
    for (int i = 0; i < 2; i++) begin
      s = rnd_stim(32'h0000A103); s.ready = 1'b0;
      e = base(3'd4); e.iord = 1'b1; e.mrd = 1'b1;
      push(s, e);
    end
    s = rnd_stim(32'h0000A103); s.ready = 1'b1; s.rst = 1'b1;
    e = base(3'd4); e.iord = 1'b1;
    push(s, e);
    add_fetch(4, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].rw !== 1'b0) begin
        errors++; $display("FAIL reset_mid_load cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [6:0] ops [5];
    logic [31:0] instr;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    clear();
    for (int n = 0; n < 40; n++) begin
      instr = {$urandom_range(0, 32'h1FFFFFF), 7'h00};
      instr[6:0] = ops[$urandom_range(0, 4)];
      add_instr(instr, (n < 10) ? 0 : int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom));
    end
    add_fetch(1, 1'b0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || (obs_q[i].mrd && obs_q[i].mwr) || (obs_q[i].rw && obs_q[i].mwr)) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_sw();
    test_trap();
    test_reset_mid_load();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
